// File: rtl/eu_cache_nport_if.sv
// Bundled IQUEUE/ALU/ICON signals of the N-operand EU operand cache.
// The slave modport is the cache side, and the master modport is the environment side.
interface eu_cache_nport_if #(
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EUIDX_W = 2,
  parameter int unsigned UID_W   = 4
);
  localparam int unsigned ADDR_W = EUIDX_W + UID_W + 1;

  logic                        instr_valid_i;
  logic [NUM_OPS-1:0]          instr_op_isreg_i;
  logic [NUM_OPS*ADDR_W-1:0]   instr_op_addr_i;
  logic [NUM_OPS*DATA_W-1:0]   instr_op_imm_i;
  logic [NUM_OPS-1:0]          instr_op_lastuse_i;
  logic                        instr_done_o;
  logic [NUM_OPS*DATA_W-1:0]   alu_op_data_o;
  logic                        alu_op_valid_o;
  logic                        alu_op_ready_i;
  logic                        alu_res_valid_i;
  logic [ADDR_W-1:0]           alu_res_addr_i;
  logic [DATA_W-1:0]           alu_res_data_i;
  logic                        alu_res_success_o;
  logic [NUM_OPS-1:0]          icon_w_valid_i;
  logic [NUM_OPS*ADDR_W-1:0]   icon_w_addr_i;
  logic [NUM_OPS*DATA_W-1:0]   icon_w_data_i;
  logic [NUM_OPS-1:0]          icon_w_success_o;
  logic                        icon_rvalid_i;
  logic [ADDR_W-1:0]           icon_raddr_i;
  logic [DATA_W-1:0]           icon_rdata_o;
  logic                        icon_rsuccess_o;

  modport slave (
    input  instr_valid_i, instr_op_isreg_i, instr_op_addr_i, instr_op_imm_i,
           instr_op_lastuse_i, alu_op_ready_i, alu_res_valid_i, alu_res_addr_i,
           alu_res_data_i, icon_w_valid_i, icon_w_addr_i, icon_w_data_i,
           icon_rvalid_i, icon_raddr_i,
    output instr_done_o, alu_op_data_o, alu_op_valid_o, alu_res_success_o,
           icon_w_success_o, icon_rdata_o, icon_rsuccess_o
  );

  modport master (
    output instr_valid_i, instr_op_isreg_i, instr_op_addr_i, instr_op_imm_i,
           instr_op_lastuse_i, alu_op_ready_i, alu_res_valid_i, alu_res_addr_i,
           alu_res_data_i, icon_w_valid_i, icon_w_addr_i, icon_w_data_i,
           icon_rvalid_i, icon_raddr_i,
    input  instr_done_o, alu_op_data_o, alu_op_valid_o, alu_res_success_o,
           icon_w_success_o, icon_rdata_o, icon_rsuccess_o
  );
endinterface

// File: rtl/eu_cache_nport.sv
// N-operand EU operand cache: direct-mapped local/rx/tx buffers plus an operand gather FSM.
// Optional macro EU_CACHE_BYPASS_EN forwards a matching local ALU result straight into a waiting hold register.
module eu_cache_nport #(
  parameter int unsigned EU_IDX        = 0,
  parameter int unsigned NUM_OPS       = 2,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned EUIDX_W       = 2,
  parameter int unsigned UID_W         = 4,
  parameter int unsigned LBUF_IDX_BITS = 3,
  parameter int unsigned XBUF_IDX_BITS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  eu_cache_nport_if.slave  bus
);
  localparam int unsigned ADDR_W = EUIDX_W + UID_W + 1;
  localparam int unsigned LN     = 1 << LBUF_IDX_BITS;
  localparam int unsigned XN     = 1 << XBUF_IDX_BITS;

  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic [DATA_W-1:0]        data_t;
  typedef logic [LBUF_IDX_BITS-1:0] lidx_t;
  typedef logic [XBUF_IDX_BITS-1:0] xidx_t;
  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_READY} state_t;

  state_t             state_q;
  logic [NUM_OPS-1:0] held_q;
  data_t              hold_q [NUM_OPS];
  logic               valid_q;
  logic               done_q;

  logic [LN-1:0] lv_q, lv_d, l_cons;
  addr_t         ltag_q  [LN];
  data_t         ldata_q [LN];
  logic [XN-1:0] txv_q, txv_d, tx_cons;
  addr_t         txtag_q  [XN];
  data_t         txdata_q [XN];
  logic [XN-1:0] rxv_q [NUM_OPS];
  logic [XN-1:0] rxv_d [NUM_OPS];
  logic [XN-1:0] rx_cons [NUM_OPS];
  addr_t         rxtag_q  [NUM_OPS][XN];
  data_t         rxdata_q [NUM_OPS][XN];

  addr_t              op_addr [NUM_OPS];
  lidx_t              op_li   [NUM_OPS];
  xidx_t              op_xi   [NUM_OPS];
  logic [NUM_OPS-1:0] op_local, op_hit, held_n;
  data_t              op_hdata [NUM_OPS];
  addr_t              w_addr [NUM_OPS];
  data_t              w_data [NUM_OPS];
  xidx_t              w_xi   [NUM_OPS];
  logic [NUM_OPS-1:0] w_ok;
  logic               issue, rd_hit, res_local, res_lwr, res_txwr;
  lidx_t              res_li;
  xidx_t              res_xi, rd_xi;
  logic [NUM_OPS*DATA_W-1:0] op_data_flat;

  always_comb begin : decode
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      op_addr[i]  = bus.instr_op_addr_i[i*ADDR_W +: ADDR_W];
      op_li[i]    = op_addr[i][LBUF_IDX_BITS:1];
      op_xi[i]    = op_addr[i][XBUF_IDX_BITS:1];
      op_local[i] = (op_addr[i][ADDR_W-1 -: EUIDX_W] == EUIDX_W'(EU_IDX));
      w_addr[i]   = bus.icon_w_addr_i[i*ADDR_W +: ADDR_W];
      w_data[i]   = bus.icon_w_data_i[i*DATA_W +: DATA_W];
      w_xi[i]     = w_addr[i][XBUF_IDX_BITS:1];
    end
  end

  // Entries freed this cycle by issue or ICON read; these block same-index writes until the next cycle.
  always_comb begin : consume
    issue   = (state_q == S_READY) && bus.alu_op_ready_i;
    l_cons  = '0;
    tx_cons = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) rx_cons[i] = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (issue && bus.instr_op_isreg_i[i] && bus.instr_op_lastuse_i[i]) begin
        if (op_local[i]) l_cons[op_li[i]] = 1'b1;
        else             rx_cons[i][op_xi[i]] = 1'b1;
      end
    end
    rd_xi  = bus.icon_raddr_i[XBUF_IDX_BITS:1];
    rd_hit = bus.icon_rvalid_i && txv_q[rd_xi] && (txtag_q[rd_xi] == bus.icon_raddr_i);
    if (rd_hit) tx_cons[rd_xi] = 1'b1;
  end

  always_comb begin : writes
    res_li    = bus.alu_res_addr_i[LBUF_IDX_BITS:1];
    res_xi    = bus.alu_res_addr_i[XBUF_IDX_BITS:1];
    res_local = (bus.alu_res_addr_i[ADDR_W-1 -: EUIDX_W] == EUIDX_W'(EU_IDX));
    res_lwr   = bus.alu_res_valid_i && res_local && !lv_q[res_li] && !l_cons[res_li];
    res_txwr  = bus.alu_res_valid_i && !res_local && !txv_q[res_xi] && !tx_cons[res_xi];
    lv_d  = lv_q & ~l_cons;
    txv_d = txv_q & ~tx_cons;
    if (res_lwr)  lv_d[res_li]  = 1'b1;
    if (res_txwr) txv_d[res_xi] = 1'b1;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      w_ok[i]  = bus.icon_w_valid_i[i] && !rxv_q[i][w_xi[i]] && !rx_cons[i][w_xi[i]];
      rxv_d[i] = rxv_q[i] & ~rx_cons[i];
      if (w_ok[i]) rxv_d[i][w_xi[i]] = 1'b1;
    end
  end

  always_comb begin : lookup
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      op_hit[i]   = 1'b0;
      op_hdata[i] = '0;
      if (bus.instr_op_isreg_i[i] && !held_q[i]) begin
        if (op_local[i]) begin
          op_hit[i]   = lv_q[op_li[i]] && (ltag_q[op_li[i]] == op_addr[i]);
          op_hdata[i] = ldata_q[op_li[i]];
`ifdef EU_CACHE_BYPASS_EN
          if (!op_hit[i] && bus.alu_res_valid_i && (bus.alu_res_addr_i == op_addr[i])) begin
            op_hit[i]   = 1'b1;
            op_hdata[i] = bus.alu_res_data_i;
          end
`else
`endif
        end else begin
          op_hit[i]   = rxv_q[i][op_xi[i]] && (rxtag_q[i][op_xi[i]] == op_addr[i]);
          op_hdata[i] = rxdata_q[i][op_xi[i]];
        end
      end
    end
    held_n = held_q | op_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin : fsm
    if (!reset_n) begin
      state_q <= S_IDLE;
      held_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_OPS; i++) hold_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (bus.instr_valid_i) begin
          held_q <= ~bus.instr_op_isreg_i;
          for (int unsigned i = 0; i < NUM_OPS; i++)
            hold_q[i] <= bus.instr_op_isreg_i[i] ? '0 : bus.instr_op_imm_i[i*DATA_W +: DATA_W];
          // All-immediate instructions skip the lookup cycle entirely.
          if (bus.instr_op_isreg_i == '0) begin
            state_q <= S_READY;
            valid_q <= 1'b1;
          end else begin
            state_q <= S_GATHER;
          end
        end
        S_GATHER: begin
          for (int unsigned i = 0; i < NUM_OPS; i++)
            if (op_hit[i]) hold_q[i] <= op_hdata[i];
          held_q <= held_n;
          if (&held_n) begin
            state_q <= S_READY;
            valid_q <= 1'b1;
          end
        end
        S_READY: if (bus.alu_op_ready_i) begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          held_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : valid_bits
    if (!reset_n) begin
      lv_q  <= '0;
      txv_q <= '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) rxv_q[i] <= '0;
    end else begin
      lv_q  <= lv_d;
      txv_q <= txv_d;
      for (int unsigned i = 0; i < NUM_OPS; i++) rxv_q[i] <= rxv_d[i];
    end
  end

  always_ff @(posedge clk) begin : payload
    if (res_lwr) begin
      ltag_q[res_li]  <= bus.alu_res_addr_i;
      ldata_q[res_li] <= bus.alu_res_data_i;
    end
    if (res_txwr) begin
      txtag_q[res_xi]  <= bus.alu_res_addr_i;
      txdata_q[res_xi] <= bus.alu_res_data_i;
    end
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (w_ok[i]) begin
        rxtag_q[i][w_xi[i]]  <= w_addr[i];
        rxdata_q[i][w_xi[i]] <= w_data[i];
      end
    end
  end

  always_comb begin : pack
    op_data_flat = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) op_data_flat[i*DATA_W +: DATA_W] = hold_q[i];
  end

  assign bus.alu_op_data_o     = op_data_flat;
  assign bus.alu_op_valid_o    = valid_q;
  assign bus.instr_done_o      = done_q;
  assign bus.alu_res_success_o = res_lwr | res_txwr;
  assign bus.icon_w_success_o  = w_ok;
  assign bus.icon_rsuccess_o   = rd_hit;
  assign bus.icon_rdata_o      = rd_hit ? txdata_q[rd_xi] : '0;
endmodule

// File: tb/tb_eu_cache_nport.sv
// Directed and randomized bench for eu_cache_nport against a table-based model of the buffers.
module tb_eu_cache_nport;
  localparam int EU_IDX = 0;
  localparam int NOPS   = 2;
  localparam int LN     = 8;
  localparam int XN     = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  eu_cache_nport_if #(.NUM_OPS(2), .DATA_W(32), .EUIDX_W(2), .UID_W(4)) bus ();

  eu_cache_nport #(
    .EU_IDX(0), .NUM_OPS(2), .DATA_W(32), .EUIDX_W(2), .UID_W(4),
    .LBUF_IDX_BITS(3), .XBUF_IDX_BITS(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    bit          v;
    logic [6:0]  tag;
    logic [31:0] data;
  } ent_t;

  ent_t lm [LN];
  ent_t txm [XN];
  ent_t rxm [NOPS][XN];
  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] mk(input int eu, input int uid, input int spec);
    return 7'(((eu & 3) << 5) | ((uid & 15) << 1) | (spec & 1));
  endfunction
  function automatic int uid_of(input logic [6:0] a);
    return int'(a[4:1]);
  endfunction
  function automatic bit is_loc(input logic [6:0] a);
    return int'(a[6:5]) == EU_IDX;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.instr_valid_i = 1'b0;
    bus.instr_op_isreg_i = '0;
    bus.instr_op_addr_i = '0;
    bus.instr_op_imm_i = '0;
    bus.instr_op_lastuse_i = '0;
    bus.alu_op_ready_i = 1'b0;
    bus.alu_res_valid_i = 1'b0;
    bus.alu_res_addr_i = '0;
    bus.alu_res_data_i = '0;
    bus.icon_w_valid_i = '0;
    bus.icon_w_addr_i = '0;
    bus.icon_w_data_i = '0;
    bus.icon_rvalid_i = 1'b0;
    bus.icon_raddr_i = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LN; i++) lm[i].v = 1'b0;
    for (int i = 0; i < XN; i++) begin
      txm[i].v = 1'b0;
      for (int c = 0; c < NOPS; c++) rxm[c][i].v = 1'b0;
    end
  endtask

  task automatic do_res(input logic [6:0] a, input logic [31:0] d, input string tag);
    int li, xi;
    bit exp;
    li = uid_of(a) % LN;
    xi = uid_of(a) % XN;
    exp = is_loc(a) ? !lm[li].v : !txm[xi].v;
    bus.alu_res_valid_i = 1'b1;
    bus.alu_res_addr_i = a;
    bus.alu_res_data_i = d;
    #1;
    chk(tag, 64'(bus.alu_res_success_o), 64'(exp));
    step();
    bus.alu_res_valid_i = 1'b0;
    if (exp) begin
      if (is_loc(a)) lm[li] = '{1'b1, a, d};
      else           txm[xi] = '{1'b1, a, d};
    end
  endtask

  task automatic do_icw(input int ch, input logic [6:0] a, input logic [31:0] d, input string tag);
    int xi;
    bit exp;
    logic [1:0] expv;
    xi = uid_of(a) % XN;
    exp = !rxm[ch][xi].v;
    expv = '0;
    expv[ch] = exp;
    bus.icon_w_valid_i = '0;
    bus.icon_w_valid_i[ch] = 1'b1;
    bus.icon_w_addr_i[ch*7 +: 7] = a;
    bus.icon_w_data_i[ch*32 +: 32] = d;
    #1;
    chk(tag, 64'(bus.icon_w_success_o), 64'(expv));
    step();
    bus.icon_w_valid_i = '0;
    if (exp) rxm[ch][xi] = '{1'b1, a, d};
  endtask

  task automatic do_rd(input logic [6:0] a, input string tag);
    int xi;
    bit hit;
    xi = uid_of(a) % XN;
    hit = txm[xi].v && (txm[xi].tag == a);
    bus.icon_rvalid_i = 1'b1;
    bus.icon_raddr_i = a;
    #1;
    chk({tag, "_hit"}, 64'(bus.icon_rsuccess_o), 64'(hit));
    if (hit) chk({tag, "_data"}, 64'(bus.icon_rdata_o), 64'(txm[xi].data));
    step();
    bus.icon_rvalid_i = 1'b0;
    if (hit) txm[xi].v = 1'b0;
  endtask

  task automatic run_instr(input logic [1:0] isreg, input logic [13:0] addrs, input logic [63:0] imms,
                           input logic [1:0] lu, input int exp_lat, input logic [63:0] exp_data,
                           input string tag);
    int c;
    logic [6:0] a;
    bus.instr_valid_i = 1'b1;
    bus.instr_op_isreg_i = isreg;
    bus.instr_op_addr_i = addrs;
    bus.instr_op_imm_i = imms;
    bus.instr_op_lastuse_i = lu;
    #1;
    c = 0;
    while (bus.alu_op_valid_o !== 1'b1 && c < 20) begin
      step();
      #1;
      c++;
    end
    chk({tag, "_lat"}, 64'(c), 64'(exp_lat));
    chk({tag, "_data"}, bus.alu_op_data_o, exp_data);
    bus.alu_op_ready_i = 1'b1;
    step();
    #1;
    chk({tag, "_done"}, 64'(bus.instr_done_o), 64'd1);
    bus.alu_op_ready_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    for (int i = 0; i < NOPS; i++) begin
      a = addrs[i*7 +: 7];
      if (isreg[i] && lu[i]) begin
        if (is_loc(a)) lm[uid_of(a) % LN].v = 1'b0;
        else           rxm[i][uid_of(a) % XN].v = 1'b0;
      end
    end
    step();
    chk({tag, "_done_pulse"}, 64'(bus.instr_done_o), 64'd0);
  endtask

  task automatic rand_instr();
    logic [1:0] isr, lu;
    logic [13:0] ad;
    logic [63:0] im, ex;
    int sel, j;
    isr = '0;
    ad = '0;
    lu = 2'($urandom_range(0, 3));
    im = {32'($urandom), 32'($urandom)};
    ex = im;
    for (int i = 0; i < NOPS; i++) begin
      sel = $urandom_range(0, 2);
      if (sel == 1) begin
        j = $urandom_range(0, LN - 1);
        if (lm[j].v) begin
          isr[i] = 1'b1;
          ad[i*7 +: 7] = lm[j].tag;
          ex[i*32 +: 32] = lm[j].data;
        end
      end else if (sel == 2) begin
        j = $urandom_range(0, XN - 1);
        if (rxm[i][j].v) begin
          isr[i] = 1'b1;
          ad[i*7 +: 7] = rxm[i][j].tag;
          ex[i*32 +: 32] = rxm[i][j].data;
        end
      end
    end
    run_instr(isr, ad, im, lu, (isr == 2'b00) ? 1 : 2, ex, "rnd_instr");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [6:0] L, F, G, S, T, A, B, R, ra;
    int c, j;
    clr_inputs();
    model_clear();
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_valid", 64'(bus.alu_op_valid_o), 64'd0);
    chk("rst_done", 64'(bus.instr_done_o), 64'd0);
    chk("rst_data", bus.alu_op_data_o, 64'd0);
    chk("rst_res_success", 64'(bus.alu_res_success_o), 64'd0);
    chk("rst_w_success", 64'(bus.icon_w_success_o), 64'd0);
    chk("rst_rsuccess", 64'(bus.icon_rsuccess_o), 64'd0);
    chk("rst_rdata", 64'(bus.icon_rdata_o), 64'd0);
    reset_n = 1'b1;
    step();

    run_instr(2'b00, 14'd0, {32'h7, 32'h5}, 2'b00, 1, {32'h7, 32'h5}, "imm2");

    L = mk(EU_IDX, 3, 0);
    do_res(L, 32'hAA, "lres_store");
    run_instr(2'b01, {7'd0, L}, {32'h11, 32'h0}, 2'b01, 2, {32'h11, 32'hAA}, "lhit");

    // Re-read of the consumed entry stalls until a new result arrives.
    bus.instr_valid_i = 1'b1;
    bus.instr_op_isreg_i = 2'b01;
    bus.instr_op_addr_i = {7'd0, L};
    bus.instr_op_imm_i = {32'h22, 32'h0};
    bus.instr_op_lastuse_i = 2'b00;
    #1;
    chk("stall_c0", 64'(bus.alu_op_valid_o), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      #1;
      chk("stall", 64'(bus.alu_op_valid_o), 64'd0);
    end
    bus.alu_res_valid_i = 1'b1;
    bus.alu_res_addr_i = L;
    bus.alu_res_data_i = 32'hBB;
    #1;
    chk("late_res_store", 64'(bus.alu_res_success_o), 64'(!lm[3].v));
    step();
    bus.alu_res_valid_i = 1'b0;
    lm[3] = '{1'b1, L, 32'hBB};
    #1;
`ifdef EU_CACHE_BYPASS_EN
    chk("bypass_n1", 64'(bus.alu_op_valid_o), 64'd1);
`else
    chk("nobypass_n1", 64'(bus.alu_op_valid_o), 64'd0);
    step();
    #1;
    chk("nobypass_n2", 64'(bus.alu_op_valid_o), 64'd1);
`endif
    chk("late_data", bus.alu_op_data_o, {32'h22, 32'hBB});
    bus.alu_op_ready_i = 1'b1;
    step();
    #1;
    chk("late_done", 64'(bus.instr_done_o), 64'd1);
    clr_inputs();
    step();
    do_res(L, 32'hCC, "no_overwrite");
    do_res(mk(EU_IDX, 11, 1), 32'hDD, "alias_blocked");

    // Foreign operand arrives on ICON channel 1 in cycle 5.
    F = mk(1, 2, 0);
    G = mk(1, 6, 0);
    bus.instr_valid_i = 1'b1;
    bus.instr_op_isreg_i = 2'b10;
    bus.instr_op_addr_i = {F, 7'd0};
    bus.instr_op_imm_i = {32'h0, 32'h1};
    bus.instr_op_lastuse_i = 2'b10;
    #1;
    chk("fwait_c0", 64'(bus.alu_op_valid_o), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      #1;
      chk("fwait", 64'(bus.alu_op_valid_o), 64'd0);
    end
    step();
    bus.icon_w_valid_i = 2'b10;
    bus.icon_w_addr_i = {F, 7'd0};
    bus.icon_w_data_i = {32'h1234, 32'h0};
    #1;
    chk("fwrite_c5", 64'(bus.icon_w_success_o), 64'd2);
    step();
    bus.icon_w_valid_i = '0;
    rxm[1][2] = '{1'b1, F, 32'h1234};
    #1;
    chk("f_c6", 64'(bus.alu_op_valid_o), 64'd0);
    step();
    #1;
    chk("f_c7", 64'(bus.alu_op_valid_o), 64'd1);
    chk("f_data", bus.alu_op_data_o, {32'h1234, 32'h1});
    bus.alu_op_ready_i = 1'b1;
    bus.icon_w_valid_i = 2'b10;
    bus.icon_w_addr_i = {G, 7'd0};
    bus.icon_w_data_i = {32'h77, 32'h0};
    #1;
    chk("rx_consume_blocks", 64'(bus.icon_w_success_o), 64'd0);
    step();
    rxm[1][2].v = 1'b0;
    bus.alu_op_ready_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    #1;
    chk("f_done", 64'(bus.instr_done_o), 64'd1);
    chk("rx_retry", 64'(bus.icon_w_success_o), 64'd2);
    step();
    bus.icon_w_valid_i = '0;
    rxm[1][2] = '{1'b1, G, 32'h77};

    S = mk(EU_IDX, 5, 1);
    do_res(S, 32'h5A, "dup_store");
    run_instr(2'b11, {S, S}, 64'd0, 2'b11, 2, {32'h5A, 32'h5A}, "dup");
    do_res(S, 32'h5B, "dup_freed");

    T = mk(2, 5, 0);
    do_res(T, 32'h99, "tx_store");
    do_rd(T, "rd1");
    do_rd(T, "rd2");

    // ICON read consuming a tx entry blocks a same-index store in that cycle.
    A = mk(2, 1, 0);
    B = mk(3, 9, 1);
    do_res(A, 32'h55, "txA_store");
    bus.icon_rvalid_i = 1'b1;
    bus.icon_raddr_i = A;
    bus.alu_res_valid_i = 1'b1;
    bus.alu_res_addr_i = B;
    bus.alu_res_data_i = 32'h66;
    #1;
    chk("rdA_hit", 64'(bus.icon_rsuccess_o), 64'd1);
    chk("rdA_data", 64'(bus.icon_rdata_o), 64'h55);
    chk("txB_blocked", 64'(bus.alu_res_success_o), 64'd0);
    step();
    bus.icon_rvalid_i = 1'b0;
    txm[1].v = 1'b0;
    #1;
    chk("txB_retry", 64'(bus.alu_res_success_o), 64'd1);
    step();
    bus.alu_res_valid_i = 1'b0;
    txm[1] = '{1'b1, B, 32'h66};
    do_rd(B, "rdB");

    // Reset while READY drops the instruction.
    R = mk(EU_IDX, 4, 0);
    do_res(R, 32'h44, "R_store");
    bus.instr_valid_i = 1'b1;
    bus.instr_op_isreg_i = 2'b01;
    bus.instr_op_addr_i = {7'd0, R};
    bus.instr_op_imm_i = {32'h3, 32'h0};
    bus.instr_op_lastuse_i = 2'b01;
    #1;
    c = 0;
    while (bus.alu_op_valid_o !== 1'b1 && c < 20) begin
      step();
      #1;
      c++;
    end
    chk("R_lat", 64'(c), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.alu_op_valid_o), 64'd0);
    chk("midrst_done", 64'(bus.instr_done_o), 64'd0);
    chk("midrst_data", bus.alu_op_data_o, 64'd0);
    clr_inputs();
    model_clear();
    step();
    step();
    reset_n = 1'b1;
    step();
    do_res(R, 32'h45, "postrst_store");

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: do_res(mk(($urandom_range(0, 1) != 0) ? EU_IDX : int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 1))),
                  32'($urandom), "rnd_res");
        1: do_icw(int'($urandom_range(0, 1)),
                  mk(int'($urandom_range(1, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1))),
                  32'($urandom), "rnd_icw");
        2: begin
          j = $urandom_range(0, XN - 1);
          if (txm[j].v && $urandom_range(0, 1) != 0) ra = txm[j].tag;
          else ra = mk(int'($urandom_range(1, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
          do_rd(ra, "rnd_rd");
        end
        default: rand_instr();
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
